// File: rtl/id_stage.sv
// id_stage: RV32I integer-ALU decode (OP-IMM, OP, LUI, AUIPC) feeding a registered ID/EX valid/ready stage.
// Build option ID_FORWARD_EN: EX/MEM operand bypass with load-use stall; undefined, any RAW hazard stalls.

module id_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       inst_i,
  input  logic                  flush_i,
  output logic                  reg1_re_o,
  output logic                  reg2_re_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]       reg1_data_i,
  input  logic [XLEN-1:0]       reg2_data_i,
  input  logic                  ex_we_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  input  logic                  ex_is_load_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]       mem_wdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ALUOP_W-1:0]    aluop_o,
  output logic [ALUSEL_W-1:0]   alusel_o,
  output logic [XLEN-1:0]       alu1_data_o,
  output logic [XLEN-1:0]       alu2_data_o,
  output logic                  w_enable_o,
  output logic [REG_ADDR_W-1:0] w_dir_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  illegal_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(10);

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3);

  typedef struct packed {
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [XLEN-1:0]       alu1;
    logic [XLEN-1:0]       alu2;
    logic                  w_enable;
    logic [REG_ADDR_W-1:0] w_dir;
    logic [XLEN-1:0]       pc;
    logic                  illegal;
  } idex_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       imm_u;
  logic [XLEN-1:0]       shamt;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = REG_ADDR_W'(inst_i[11:7]);
  assign rs1    = REG_ADDR_W'(inst_i[19:15]);
  assign rs2    = REG_ADDR_W'(inst_i[24:20]);
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign shamt  = XLEN'(inst_i[24:20]);

  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                re1;
  logic                re2;
  logic                is_op;
  logic                is_shift;
  logic                is_lui;
  logic                is_auipc;
  logic                bad;

  // Opcode/funct decode; an illegal encoding uses no sources and produces a NOP.
  always_comb begin
    dec_aluop  = ALU_NOP;
    dec_alusel = SEL_NOP;
    re1        = 1'b0;
    re2        = 1'b0;
    is_op      = 1'b0;
    is_shift   = 1'b0;
    is_lui     = 1'b0;
    is_auipc   = 1'b0;
    bad        = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        re1 = 1'b1;
        case (funct3)
          3'b000: begin dec_aluop = ALU_ADD;  dec_alusel = SEL_ARITH; end
          3'b010: begin dec_aluop = ALU_SLT;  dec_alusel = SEL_ARITH; end
          3'b011: begin dec_aluop = ALU_SLTU; dec_alusel = SEL_ARITH; end
          3'b100: begin dec_aluop = ALU_XOR;  dec_alusel = SEL_LOGIC; end
          3'b110: begin dec_aluop = ALU_OR;   dec_alusel = SEL_LOGIC; end
          3'b111: begin dec_aluop = ALU_AND;  dec_alusel = SEL_LOGIC; end
          3'b001: begin
            is_shift   = 1'b1;
            dec_aluop  = ALU_SLL;
            dec_alusel = SEL_SHIFT;
            bad        = (funct7 != F7_BASE);
          end
          3'b101: begin
            is_shift   = 1'b1;
            dec_aluop  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_alusel = SEL_SHIFT;
            bad        = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        re1   = 1'b1;
        re2   = 1'b1;
        is_op = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: begin dec_aluop = ALU_ADD;  dec_alusel = SEL_ARITH; end
            3'b001: begin dec_aluop = ALU_SLL;  dec_alusel = SEL_SHIFT; end
            3'b010: begin dec_aluop = ALU_SLT;  dec_alusel = SEL_ARITH; end
            3'b011: begin dec_aluop = ALU_SLTU; dec_alusel = SEL_ARITH; end
            3'b100: begin dec_aluop = ALU_XOR;  dec_alusel = SEL_LOGIC; end
            3'b101: begin dec_aluop = ALU_SRL;  dec_alusel = SEL_SHIFT; end
            3'b110: begin dec_aluop = ALU_OR;   dec_alusel = SEL_LOGIC; end
            3'b111: begin dec_aluop = ALU_AND;  dec_alusel = SEL_LOGIC; end
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_aluop  = ALU_SUB;
          dec_alusel = SEL_ARITH;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_aluop  = ALU_SRA;
          dec_alusel = SEL_SHIFT;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_LUI: begin
        is_lui     = 1'b1;
        dec_aluop  = ALU_ADD;
        dec_alusel = SEL_ARITH;
      end
      OPC_AUIPC: begin
        is_auipc   = 1'b1;
        dec_aluop  = ALU_ADD;
        dec_alusel = SEL_ARITH;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec_aluop  = ALU_NOP;
      dec_alusel = SEL_NOP;
      re1        = 1'b0;
      re2        = 1'b0;
      is_op      = 1'b0;
      is_shift   = 1'b0;
    end
  end

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            stall;

`ifdef ID_FORWARD_EN
  // EX bypass wins over MEM; a load in EX has no data yet and cannot bypass.
  always_comb begin
    src1 = reg1_data_i;
    src2 = reg2_data_i;
    if (ex_we_i && !ex_is_load_i && ex_waddr_i == rs1) src1 = ex_wdata_i;
    else if (mem_we_i && mem_waddr_i == rs1)           src1 = mem_wdata_i;
    if (ex_we_i && !ex_is_load_i && ex_waddr_i == rs2) src2 = ex_wdata_i;
    else if (mem_we_i && mem_waddr_i == rs2)           src2 = mem_wdata_i;
    if (rs1 == '0) src1 = '0;
    if (rs2 == '0) src2 = '0;
  end

  assign stall = ex_is_load_i && ex_we_i && (ex_waddr_i != '0) &&
                 ((re1 && rs1 == ex_waddr_i) || (re2 && rs2 == ex_waddr_i));
`else
  logic hit1;
  logic hit2;
  logic unused_fwd;

  assign src1 = (rs1 == '0) ? '0 : reg1_data_i;
  assign src2 = (rs2 == '0) ? '0 : reg2_data_i;
  // Without bypass, any pending writer of a used source holds the instruction in IF.
  assign hit1 = re1 && (rs1 != '0) &&
                ((ex_we_i && ex_waddr_i == rs1) || (mem_we_i && mem_waddr_i == rs1));
  assign hit2 = re2 && (rs2 != '0) &&
                ((ex_we_i && ex_waddr_i == rs2) || (mem_we_i && mem_waddr_i == rs2));
  assign stall = hit1 || hit2;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  idex_t dec;

  // Operand selection and payload assembly.
  always_comb begin
    dec          = '0;
    dec.aluop    = dec_aluop;
    dec.alusel   = dec_alusel;
    dec.w_enable = !bad && (rd != '0);
    dec.w_dir    = rd;
    dec.pc       = pc_i;
    dec.illegal  = bad;
    if (is_lui)        dec.alu1 = imm_u;
    else if (is_auipc) dec.alu1 = pc_i;
    else if (re1)      dec.alu1 = src1;
    if (is_op)         dec.alu2 = src2;
    else if (is_shift) dec.alu2 = shamt;
    else if (is_auipc) dec.alu2 = imm_u;
    else if (re1)      dec.alu2 = imm_i;
  end

  assign reg1_re_o   = re1;
  assign reg2_re_o   = re2;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  logic  valid_q;
  idex_t q;
  logic  accept;

  assign in_ready_o = (!valid_q || out_ready_i) && !stall && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  // ID/EX register: flush beats load and hold; drains when EX takes the op and nothing new arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign aluop_o     = q.aluop;
  assign alusel_o    = q.alusel;
  assign alu1_data_o = q.alu1;
  assign alu2_data_o = q.alu2;
  assign w_enable_o  = q.w_enable;
  assign w_dir_o     = q.w_dir;
  assign pc_o        = q.pc;
  assign illegal_o   = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, multi-cycle hazard/hold/flush/reset sequences, random vs model.
module tb_id_stage;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc, inst;
  logic        reg1_re, reg2_re;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic        ex_we, ex_is_load, mem_we;
  logic [4:0]  ex_waddr, mem_waddr;
  logic [31:0] ex_wdata, mem_wdata;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] alu1, alu2, pc_out;
  logic        w_enable, illegal;
  logic [4:0]  w_dir;

  logic [31:0] regs [32];
  assign reg1_data = regs[reg1_addr];
  assign reg2_data = regs[reg2_addr];

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc), .inst_i(inst),
    .flush_i(flush), .reg1_re_o(reg1_re), .reg2_re_o(reg2_re), .reg1_addr_o(reg1_addr),
    .reg2_addr_o(reg2_addr), .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .aluop_o(aluop), .alusel_o(alusel),
    .alu1_data_o(alu1), .alu2_data_o(alu2), .w_enable_o(w_enable), .w_dir_o(w_dir),
    .pc_o(pc_out), .illegal_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  sel;
    logic [31:0] a1, a2, pc;
    logic        we, ill, re1, re2;
    logic [4:0]  wd, rs1, rs2;
  } exp_t;

  typedef struct {
    logic [31:0] inst, pc;
    logic        exw; logic [4:0] exa; logic [31:0] exd; logic exl;
    logic        mw;  logic [4:0] ma;  logic [31:0] md;
    logic        rdy;
    logic [7:0]  aluop; logic [2:0] sel; logic [31:0] a1, a2;
    logic        we; logic [4:0] wd; logic ill;
  } vec_t;

  // Architectural value a source would see, given the writers currently in flight.
  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (FWD && ex_we && !ex_is_load && ex_waddr == a) return ex_wdata;
    if (FWD && mem_we && mem_waddr == a) return mem_wdata;
    return regs[a];
  endfunction

  function automatic logic [7:0] f3_op(input logic [2:0] f3);
    logic [7:0] tbl [8];
    tbl = '{8'd1, 8'd8, 8'd3, 8'd4, 8'd5, 8'd9, 8'd6, 8'd7};
    return tbl[f3];
  endfunction

  function automatic logic [2:0] op_class(input logic [7:0] op);
    if (op == 8'd5 || op == 8'd6 || op == 8'd7) return 3'd1;
    if (op >= 8'd8) return 3'd2;
    return 3'd3;
  endfunction

  function automatic exp_t model(input logic [31:0] in, input logic [31:0] p);
    exp_t e;
    logic legal;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [7:0] op;
    f7 = in[31:25]; f3 = in[14:12];
    e = '{default: '0};
    e.pc = p; e.wd = in[11:7]; e.rs1 = in[19:15]; e.rs2 = in[24:20];
    legal = 1'b1; op = 8'd0;
    case (in[6:0])
      7'h13: begin
        op = f3_op(f3);
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) op = 8'd10;
        end
        e.re1 = 1'b1;
        e.a1 = src_val(e.rs1);
        e.a2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'h0, in[24:20]} : {{20{in[31]}}, in[31:20]};
      end
      7'h33: begin
        op = f3_op(f3);
        if (f7 == 7'h20 && f3 == 3'd0) op = 8'd2;
        else if (f7 == 7'h20 && f3 == 3'd5) op = 8'd10;
        else if (f7 != 7'h00) legal = 1'b0;
        e.re1 = 1'b1; e.re2 = 1'b1;
        e.a1 = src_val(e.rs1);
        e.a2 = src_val(e.rs2);
      end
      7'h37: begin op = 8'd1; e.a1 = {in[31:12], 12'h0}; e.a2 = 0; end
      7'h17: begin op = 8'd1; e.a1 = p; e.a2 = {in[31:12], 12'h0}; end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      e.aluop = op; e.sel = op_class(op); e.we = (e.wd != 0);
    end else begin
      e.ill = 1'b1; e.re1 = 1'b0; e.re2 = 1'b0;
    end
    return e;
  endfunction

  function automatic bit pending(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (FWD) return ex_is_load && ex_we && ex_waddr == a;
    return (ex_we && ex_waddr == a) || (mem_we && mem_waddr == a);
  endfunction

  function automatic bit model_stall(input exp_t e);
    return (e.re1 && pending(e.rs1)) || (e.re2 && pending(e.rs2));
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".aluop"}, 32'(aluop), 32'(e.aluop));
    chk({tag, ".alusel"}, 32'(alusel), 32'(e.sel));
    chk({tag, ".w_enable"}, 32'(w_enable), 32'(e.we));
    chk({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({tag, ".pc"}, pc_out, e.pc);
    if (!e.ill) begin
      chk({tag, ".alu1"}, alu1, e.a1);
      chk({tag, ".alu2"}, alu2, e.a2);
      chk({tag, ".w_dir"}, 32'(w_dir), 32'(e.wd));
    end
  endtask

  task automatic set_hz(input logic exw, input logic [4:0] exa, input logic [31:0] exd, input logic exl,
                        input logic mw, input logic [4:0] ma, input logic [31:0] md);
    ex_we = exw; ex_waddr = exa; ex_wdata = exd; ex_is_load = exl;
    mem_we = mw; mem_waddr = ma; mem_wdata = md;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] r1, r2, d;
    logic [2:0] f3;
    logic [6:0] f7;
    r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    f3 = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h20;
      1: f7 = 7'($urandom);
      default: f7 = 7'h00;
    endcase
    case ($urandom_range(0, 5))
      0, 1: return {f7, 5'($urandom), r1, f3, d, 7'h13};
      2: return {f7, r2, r1, f3, d, 7'h33};
      3: return {20'($urandom), d, 7'h37};
      4: return {20'($urandom), d, 7'h17};
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs [15];
  exp_t e, mq;
  bit   mv, rdy;

  initial begin
    rst = 1'b0; in_valid = 0; out_ready = 1; flush = 0; pc = 0; inst = 0;
    set_hz(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.aluop", 32'(aluop), 0);
    chk("reset.alusel", 32'(alusel), 0);
    chk("reset.alu1", alu1, 0);
    chk("reset.alu2", alu2, 0);
    chk("reset.w_enable", 32'(w_enable), 0);
    chk("reset.illegal", 32'(illegal), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{32'hFFF00093, 0,     0, 0, 0, 0,             0, 0, 0,            1,   8'd1,  3'd3, 32'h0,      32'hFFFFFFFF, 1, 5'd1,  0};
    vecs[1]  = '{32'h0F00E113, 0,     1, 1, 32'h1234, 0,      0, 0, 0,            FWD, 8'd6,  3'd1, 32'h1234,   32'hF0,       1, 5'd2,  0};
    vecs[2]  = '{32'h0F00E113, 0,     1, 1, 32'h1234, 0,      1, 1, 32'h5555,     FWD, 8'd6,  3'd1, 32'h1234,   32'hF0,       1, 5'd2,  0};
    vecs[3]  = '{32'h0F00E113, 0,     0, 0, 0, 0,             1, 1, 32'h5555,     FWD, 8'd6,  3'd1, 32'h5555,   32'hF0,       1, 5'd2,  0};
    vecs[4]  = '{32'h00518233, 0,     1, 3, 32'hAAAA, 1,      0, 0, 0,            0,   8'd1,  3'd3, 32'h1003,   32'h1005,     1, 5'd4,  0};
    vecs[5]  = '{32'h40208333, 4,     0, 0, 0, 0,             0, 0, 0,            1,   8'd2,  3'd3, 32'h1001,   32'h1002,     1, 5'd6,  0};
    vecs[6]  = '{32'h4020D3B3, 8,     0, 0, 0, 0,             0, 0, 0,            1,   8'd10, 3'd2, 32'h1001,   32'h1002,     1, 5'd7,  0};
    vecs[7]  = '{32'h4040D413, 12,    0, 0, 0, 0,             0, 0, 0,            1,   8'd10, 3'd2, 32'h1001,   32'h4,        1, 5'd8,  0};
    vecs[8]  = '{32'h02208033, 16,    0, 0, 0, 0,             0, 0, 0,            1,   8'd0,  3'd0, 32'h0,      32'h0,        0, 5'd1,  1};
    vecs[9]  = '{32'h000000FF, 20,    0, 0, 0, 0,             0, 0, 0,            1,   8'd0,  3'd0, 32'h0,      32'h0,        0, 5'd1,  1};
    vecs[10] = '{32'h00500013, 24,    0, 0, 0, 0,             0, 0, 0,            1,   8'd1,  3'd3, 32'h0,      32'h5,        0, 5'd0,  0};
    vecs[11] = '{32'hABCDE4B7, 32'h40, 0, 0, 0, 0,            0, 0, 0,            1,   8'd1,  3'd3, 32'hABCDE000, 32'h0,      1, 5'd9,  0};
    vecs[12] = '{32'h12345517, 32'h80, 0, 0, 0, 0,            0, 0, 0,            1,   8'd1,  3'd3, 32'h80,     32'h12345000, 1, 5'd10, 0};
    vecs[13] = '{32'h00700593, 28,    1, 0, 32'hFFFF, 0,      0, 0, 0,            1,   8'd1,  3'd3, 32'h0,      32'h7,        1, 5'd11, 0};
    vecs[14] = '{32'hFFE0B613, 36,    0, 0, 0, 0,             0, 0, 0,            1,   8'd4,  3'd3, 32'h1001,   32'hFFFFFFFE, 1, 5'd12, 0};

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      inst = vecs[i].inst; pc = vecs[i].pc; in_valid = 1; out_ready = 1;
      set_hz(vecs[i].exw, vecs[i].exa, vecs[i].exd, vecs[i].exl, vecs[i].mw, vecs[i].ma, vecs[i].md);
      #1;
      chk({t, ".in_ready"}, 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      chk({t, ".out_valid"}, 32'(out_valid), 32'(vecs[i].rdy));
      if (vecs[i].rdy) begin
        e = '{aluop: vecs[i].aluop, sel: vecs[i].sel, a1: vecs[i].a1, a2: vecs[i].a2, pc: vecs[i].pc,
              we: vecs[i].we, ill: vecs[i].ill, re1: 0, re2: 0, wd: vecs[i].wd, rs1: 0, rs2: 0};
        cmp_out(t, e);
      end
      in_valid = 0;
      set_hz(0, 0, 0, 0, 0, 0, 0);
    end

    // Load-use: ADD x4,x3,x5 behind a load of x3 stalls, pipeline drains, then issues on release.
    inst = 32'hFFF00093; pc = 32'h100; in_valid = 1;
    @(posedge clk); #1;
    inst = 32'h00518233; pc = 32'h104;
    set_hz(1, 3, 32'hBEEF, 1, 0, 0, 0);
    #1;
    chk("lu.in_ready0", 32'(in_ready), 0);
    chk("lu.valid_before", 32'(out_valid), 1);
    @(posedge clk); #1;
    chk("lu.drain", 32'(out_valid), 0);
    chk("lu.in_ready1", 32'(in_ready), 0);
    set_hz(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lu.release_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("lu.issued", 32'(out_valid), 1);
    chk("lu.alu1", alu1, 32'h1003);
    chk("lu.alu2", alu2, 32'h1005);
    chk("lu.pc", pc_out, 32'h104);

    // Hold under backpressure for three cycles, then flush with EX still stalled.
    inst = 32'h40208333; pc = 32'h200;
    @(posedge clk); #1;
    out_ready = 0; inst = 32'hFFF00093; pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold.in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("hold.valid", 32'(out_valid), 1);
      chk("hold.aluop", 32'(aluop), 2);
      chk("hold.alu1", alu1, 32'h1001);
      chk("hold.pc", pc_out, 32'h200);
    end
    flush = 1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("flush.valid", 32'(out_valid), 0);
    flush = 0; out_ready = 1;

    // Asynchronous reset mid-cycle clears the stage before the next edge.
    inst = 32'h00500013; pc = 32'h300;
    @(posedge clk); #1;
    chk("areset.pre_valid", 32'(out_valid), 1);
    #2 rst = 0;
    #1;
    chk("areset.valid", 32'(out_valid), 0);
    chk("areset.alu2", alu2, 0);
    chk("areset.aluop", 32'(aluop), 0);
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    // Random traffic against the behavioural model.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    mv = 0;
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      inst = rand_inst(); pc = {$urandom} & 32'hFFFFFFFC;
      set_hz($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      #1;
      e = model(inst, pc);
      rdy = (!mv || out_ready) && !model_stall(e) && !flush;
      chk("rnd.in_ready", 32'(in_ready), 32'(rdy));
      chk("rnd.reg1_re", 32'(reg1_re), 32'(e.re1));
      chk("rnd.reg2_re", 32'(reg2_re), 32'(e.re2));
      if (e.re1) chk("rnd.reg1_addr", 32'(reg1_addr), 32'(e.rs1));
      if (e.re2) chk("rnd.reg2_addr", 32'(reg2_addr), 32'(e.rs2));
      @(posedge clk); #1;
      if (flush) mv = 0;
      else if (in_valid && rdy) begin mv = 1; mq = e; end
      else if (out_ready) mv = 0;
      chk("rnd.out_valid", 32'(out_valid), 32'(mv));
      if (mv) cmp_out("rnd", mq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised successor decode stage: decodes the full RV32I integer ALU subset (OP-IMM, OP, LUI, AUIPC) instead of ORI only.
- Adds a registered ID/EX output with a valid/ready handshake, operand forwarding from EX and MEM, load-use stall and flush.
- Sits between IF and EX; reads the regfile combinationally through reg1/reg2 read ports.

Parameters:
- XLEN, 32, data/instruction width
- REG_ADDR_W, 5, register address width
- ALUOP_W, 8, aluop_o width
- ALUSEL_W, 3, alusel_o width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid_i  in  1  IF presents an instruction
- in_ready_o  out  1  stage accepts the instruction this cycle
- pc_i  in  XLEN  instruction PC
- inst_i  in  XLEN  instruction word
- flush_i  in  1  kill the incoming and held instruction
- reg1_re_o / reg2_re_o  out  1  regfile read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  REG_ADDR_W  rs1/rs2 (combinational)
- reg1_data_i / reg2_data_i  in  XLEN  regfile read data
- ex_we_i, ex_waddr_i, ex_wdata_i, ex_is_load_i  in  1/REG_ADDR_W/XLEN/1  EX-stage writer
- mem_we_i, mem_waddr_i, mem_wdata_i  in  1/REG_ADDR_W/XLEN  MEM-stage writer
- out_valid_o  out  1  ID/EX register holds a valid op
- out_ready_i  in  1  EX accepts the op
- aluop_o  out  ALUOP_W  NOP=0 ADD=1 SUB=2 SLT=3 SLTU=4 XOR=5 OR=6 AND=7 SLL=8 SRL=9 SRA=10
- alusel_o  out  ALUSEL_W  NOP=0 LOGIC=1 SHIFT=2 ARITH=3
- alu1_data_o / alu2_data_o  out  XLEN  operands
- w_enable_o  out  1  write-back enable
- w_dir_o  out  REG_ADDR_W  rd
- pc_o  out  XLEN  PC of the op
- illegal_o  out  1  undecodable instruction

Behaviour:
- Reset (rst=0, async): all registered outputs are 0 (out_valid_o=0, aluop/alusel NOP, operands 0, w_enable_o=0, illegal_o=0).
- Decode is combinational. Accept when in_valid_i && in_ready_o. The ID/EX register loads on the next rising edge; latency is 1 cycle.
- in_ready_o = (!out_valid_o || out_ready_i) && !stall && !flush_i.
- Hold: if out_valid_o && !out_ready_i, all outputs stay stable.
- Drain: if out_ready_i and nothing is accepted, out_valid_o clears.
- Immediates: I-type is sign-extended imm[11:0]. Shift amount is inst[24:20] zero-extended. LUI operand1 = {imm_U,12'b0}, operand2 = 0 (ADD). AUIPC operand1 = pc_i, operand2 = {imm_U,12'b0} (ADD).
- Operand1 is rs1 data unless LUI/AUIPC. Operand2 is rs2 data for OP, immediate otherwise. Read enables are set only for sources actually used.
- OP uses funct7 0x00/0x20 to select ADD/SUB and SRL/SRA. Any other funct7, or an unknown opcode, sets illegal_o=1 with aluop/alusel NOP and w_enable_o=0, and still flows with out_valid_o=1.
- rd==0: w_enable_o=0.
- Source x0 always reads 0 regardless of forwarding.
- Forward priority: EX (ex_we_i && addr match && !ex_is_load_i), then MEM, then regfile.
- Load-use stall: ex_is_load_i && ex_we_i && ex_waddr_i!=0 && match on an enabled source. The op is not accepted and is held by IF.
- flush_i: on the next edge out_valid_o=0, flush overrides load and hold; in_ready_o is 0 that cycle.

Optional Feature:
- Macro ID_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: no bypass muxes; stall = any enabled nonzero source matching ex_waddr_i (ex_we_i) or mem_waddr_i (mem_we_i). Operands come only from regfile data.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, aluop=1, alusel=3, alu1=0, alu2=0xFFFFFFFF, w_dir=1, w_enable=1.
- ORI x2,x1,0x0F0 with ex_we=1, ex_waddr=1, ex_wdata=0x1234 -> alu1=0x1234, aluop=6; with MEM also writing x1=0x5555, EX still wins. Without ID_FORWARD_EN: in_ready=0 until ex_we drops.
- ex_is_load=1 writing x3, then ADD x4,x3,x5 -> in_ready=0 and out_valid drains to 0; release -> op accepted next cycle.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; flush_i pulse -> out_valid=0 next edge.
- Funct7=0x01 on OP, and opcode 0x7F -> illegal_o=1, aluop=0, w_enable=0. ADDI x0,x0,5 -> w_enable=0.
- Assert rst low mid-stream asynchronously -> out_valid_o=0 immediately, before the next clk edge.
